// File: rtl/rf_ctrl_pkg.sv
// Package: rf_ctrl_pkg
//  Shared register-file write-path defaults and types.
//  D_WIDTH / NUM_REG / SEL_WIDTH : default data width, register count, address width
//  reg_addr_t / reg_data_t       : register address and data words
//  rf_wr_t                       : one staged register-file write {addr, data}
package rf_ctrl_pkg;
   localparam int D_WIDTH   = 34;
   localparam int NUM_REG   = 8;
   localparam int SEL_WIDTH = 3;

   typedef logic [SEL_WIDTH-1:0] reg_addr_t;
   typedef logic [D_WIDTH-1:0]   reg_data_t;

   typedef struct packed {
      reg_addr_t addr;
      reg_data_t data;
   } rf_wr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Module: rr_arbiter
//  Round-robin arbiter. The scan starts at the pointer and moves upward,
//  wrapping modulo N. The first active request wins. After a grant, the
//  pointer moves to the slot just past the winner. With no grant, it holds.
// Ports
//  clk   in  1  clock, rising edge
//  rst_n in  1  asynchronous active-low reset (pointer -> 0)
//  req   in  N  request vector
//  gnt   out N  one-hot grant (combinational), all-zero when no request
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt_idx;
   logic          any;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[(int'(ptr) + i) % N]) begin
            any                     = 1'b1;
            gnt[(int'(ptr) + i) % N] = 1'b1;
            gnt_idx                 = PW'((int'(ptr) + i) % N);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (any)
         ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
   end
endmodule

// File: rtl/rf_write_scheduler.sv
// Module: rf_write_scheduler
//  Shares the single register-file write port among NUM_REQ producers by
//  round-robin arbitration. The granted write is staged for one cycle and
//  then driven onto the register_file wen/wa/wd inputs. A per-register busy
//  scoreboard is set at issue and cleared when the write commits.
// Ports
//  clk, rst_n_i             clock / async active-low reset
//  req_valid_i/addr_i/data_i  per-requester write requests (k at [k*W +: W])
//  req_ready_o              one-hot grant; transfer on valid & ready
//  rsv_valid_i/rsv_addr_i   issue-stage destination reservation
//  busy_o                   scoreboard, bit r set while r awaits its write
//  rf_wen_o/rf_wa_o/rf_wd_o registered write port to register_file
//  wr_unrsv_o               pulse: a committed write hit a non-busy register
// Optional (macro RF_WR_BYPASS_EN)
//  byp_ra_i  in  3 read addresses; byp_hit_o out per-reader hit on the
//  committing write; byp_data_o out the committing write data.
module rf_write_scheduler
   import rf_ctrl_pkg::*;
#(
   parameter int D_WIDTH   = rf_ctrl_pkg::D_WIDTH,
   parameter int NUM_REG   = rf_ctrl_pkg::NUM_REG,
   parameter int SEL_WIDTH = rf_ctrl_pkg::SEL_WIDTH,
   parameter int NUM_REQ   = 3
) (
   input  logic                         clk,
   input  logic                         rst_n_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*SEL_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*D_WIDTH-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   input  logic                         rsv_valid_i,
   input  logic [SEL_WIDTH-1:0]         rsv_addr_i,
   output logic [NUM_REG-1:0]           busy_o,
   output logic                         rf_wen_o,
   output logic [SEL_WIDTH-1:0]         rf_wa_o,
   output logic [D_WIDTH-1:0]           rf_wd_o,
   output logic                         wr_unrsv_o
`ifdef RF_WR_BYPASS_EN
   ,
   input  logic [3*SEL_WIDTH-1:0]       byp_ra_i,
   output logic [2:0]                   byp_hit_o,
   output logic [D_WIDTH-1:0]           byp_data_o
`endif
);
   logic [NUM_REQ-1:0]   gnt;
   logic [SEL_WIDTH-1:0] sel_addr;
   logic [D_WIDTH-1:0]   sel_data;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk   (clk),
      .rst_n (rst_n_i),
      .req   (req_valid_i),
      .gnt   (gnt)
   );

   assign req_ready_o = gnt;

   // Grant is one-hot, so an OR-reduction acts as the mux.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k]) begin
            sel_addr = sel_addr | req_addr_i[k*SEL_WIDTH +: SEL_WIDTH];
            sel_data = sel_data | req_data_i[k*D_WIDTH +: D_WIDTH];
         end
      end
   end

   // Write stage: wa/wd hold when idle and only wen drops.
   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rf_wen_o <= 1'b0;
         rf_wa_o  <= '0;
         rf_wd_o  <= '0;
      end else begin
         rf_wen_o <= |gnt;
         if (|gnt) begin
            rf_wa_o <= sel_addr;
            rf_wd_o <= sel_data;
         end
      end
   end

   // Scoreboard. A set takes priority over a clear, so a reservation made in
   // the same cycle as an older write to that register still stands.
   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_o     <= '0;
         wr_unrsv_o <= 1'b0;
      end else begin
         wr_unrsv_o <= rf_wen_o && !busy_o[rf_wa_o];
         for (int r = 0; r < NUM_REG; r++) begin
            if (rsv_valid_i && int'(rsv_addr_i) == r)
               busy_o[r] <= 1'b1;
            else if (rf_wen_o && int'(rf_wa_o) == r)
               busy_o[r] <= 1'b0;
         end
      end
   end

`ifdef RF_WR_BYPASS_EN
   // Forward the value that commits this cycle to same-cycle readers.
   always_comb begin
      for (int j = 0; j < 3; j++)
         byp_hit_o[j] = rf_wen_o && (rf_wa_o == byp_ra_i[j*SEL_WIDTH +: SEL_WIDTH]);
   end
   assign byp_data_o = rf_wd_o;
`else
   // No bypass: readers wait one cycle after busy clears.
`endif
endmodule

// File: tb/tb_rf_write_scheduler.sv
module tb_rf_write_scheduler;
   logic        clk = 1'b0;
   logic        rst_n_i;
   logic [2:0]  req_valid_i;
   logic [8:0]  req_addr_i;
   logic [101:0] req_data_i;
   logic [2:0]  req_ready_o;
   logic        rsv_valid_i;
   logic [2:0]  rsv_addr_i;
   logic [7:0]  busy_o;
   logic        rf_wen_o;
   logic [2:0]  rf_wa_o;
   logic [33:0] rf_wd_o;
   logic        wr_unrsv_o;
`ifdef RF_WR_BYPASS_EN
   logic [8:0]  byp_ra_i;
   logic [2:0]  byp_hit_o;
   logic [33:0] byp_data_o;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rf_write_scheduler dut (
      .clk(clk), .rst_n_i(rst_n_i),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .req_ready_o(req_ready_o), .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i),
      .busy_o(busy_o), .rf_wen_o(rf_wen_o), .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o),
      .wr_unrsv_o(wr_unrsv_o)
`ifdef RF_WR_BYPASS_EN
      , .byp_ra_i(byp_ra_i), .byp_hit_o(byp_hit_o), .byp_data_o(byp_data_o)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [2:0]   vld;
      logic [8:0]   addr;
      logic [101:0] data;
      logic [2:0]   rdy;
      logic         wen;
      logic [2:0]   wa;
      logic [33:0]  wd;
      logic         unrsv;
   } vec_t;

   function automatic vec_t mkv(logic [2:0] v, logic [8:0] a, logic [101:0] d,
                                logic [2:0] r, logic w, logic [2:0] wa,
                                logic [33:0] wd, logic u);
      vec_t x;
      x.vld = v; x.addr = a; x.data = d; x.rdy = r;
      x.wen = w; x.wa = wa; x.wd = wd; x.unrsv = u;
      return x;
   endfunction

   task automatic drive(input logic [2:0] v, input logic [8:0] a, input logic [101:0] d,
                        input logic rv, input logic [2:0] ra);
      req_valid_i = v; req_addr_i = a; req_data_i = d;
      rsv_valid_i = rv; rsv_addr_i = ra;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(3'b0, '0, '0, 1'b0, 3'd0);
`ifdef RF_WR_BYPASS_EN
      byp_ra_i = '0;
`endif
      rst_n_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n_i = 1'b1;
      tick();
   endtask

   // Reference model state
   int         m_ptr;
   logic [7:0] m_busy;
   logic       m_wen, m_unrsv;
   logic [2:0] m_wa;
   logic [33:0] m_wd;

   // Winner: the valid requester closest to the pointer, measured upward mod 3.
   function automatic int mdl_win(logic [2:0] v, int p);
      int best = -1;
      int bd = 99;
      for (int k = 0; k < 3; k++)
         if (v[k] && ((k - p + 3) % 3) < bd) begin
            bd = (k - p + 3) % 3;
            best = k;
         end
      return best;
   endfunction

   localparam logic [2:0]  A0 = 3'd1, A1 = 3'd2, A2 = 3'd3;
   localparam logic [33:0] D0 = 34'h0_0000_AAAA, D1 = 34'h1_0000_BBBB, D2 = 34'h2_CCCC_CCCC;
   localparam logic [33:0] D7 = 34'h3_0000_0007;

   vec_t tbl[10];

   // Random-phase requester bookkeeping
   logic [2:0]  pv;
   logic [2:0]  pa[3];
   logic [33:0] pd[3];

   initial begin
      // Directed vectors applied back-to-back from reset
      for (int i = 0; i < 6; i++)
         tbl[i] = mkv(3'b111, {A2, A1, A0}, {D2, D1, D0}, 3'b001 << (i % 3), 1'b1,
                      (i % 3 == 0) ? A0 : (i % 3 == 1) ? A1 : A2,
                      (i % 3 == 0) ? D0 : (i % 3 == 1) ? D1 : D2, i != 0);
      tbl[6] = mkv(3'b010, {3'd0, 3'd5, 3'd0}, {34'h0, 34'h1_2345, 34'h0}, 3'b010, 1'b1, 3'd5, 34'h1_2345, 1'b1);
      tbl[7] = mkv(3'b001, {3'd0, 3'd0, 3'd7}, {34'h0, 34'h0, D7}, 3'b001, 1'b1, 3'd7, D7, 1'b1);
      tbl[8] = mkv(3'b000, '0, '0, 3'b000, 1'b0, 3'd7, D7, 1'b1);
      tbl[9] = mkv(3'b111, {A2, A1, A0}, {D2, D1, D0}, 3'b010, 1'b1, A1, D1, 1'b0);

      do_reset();
      chk("rst_wen", rf_wen_o, 1'b0);
      chk("rst_wa", rf_wa_o, 3'd0);
      chk("rst_wd", rf_wd_o, 34'd0);
      chk("rst_busy", busy_o, 8'd0);
      chk("rst_unrsv", wr_unrsv_o, 1'b0);
      chk("rst_ready", req_ready_o, 3'b000);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].vld, tbl[i].addr, tbl[i].data, 1'b0, 3'd0);
         #1;
         chk($sformatf("tbl%0d_ready", i), req_ready_o, tbl[i].rdy);
         tick();
         chk($sformatf("tbl%0d_wen", i), rf_wen_o, tbl[i].wen);
         chk($sformatf("tbl%0d_wa", i), rf_wa_o, tbl[i].wa);
         chk($sformatf("tbl%0d_wd", i), rf_wd_o, tbl[i].wd);
         chk($sformatf("tbl%0d_unrsv", i), wr_unrsv_o, tbl[i].unrsv);
         chk($sformatf("tbl%0d_busy", i), busy_o, 8'd0);
      end

      // Scoreboard: set beats a same-cycle clear, and a later write clears it
      do_reset();
      drive(3'b000, '0, '0, 1'b1, 3'd3); tick();
      chk("sb_rsv3", busy_o, 8'h08);
      drive(3'b001, {3'd0, 3'd0, 3'd3}, {68'h0, 34'h11}, 1'b0, 3'd0); tick();
      chk("sb_wr3_wen", rf_wen_o, 1'b1);
      chk("sb_wr3_wa", rf_wa_o, 3'd3);
      drive(3'b000, '0, '0, 1'b1, 3'd3); tick();
      chk("sb_setwins_busy", busy_o, 8'h08);
      chk("sb_setwins_unrsv", wr_unrsv_o, 1'b0);
      drive(3'b010, {3'd0, 3'd3, 3'd0}, {34'h0, 34'h22, 34'h0}, 1'b0, 3'd0); tick();
      chk("sb_wr3b_busy", busy_o, 8'h08);
      drive(3'b000, '0, '0, 1'b0, 3'd0); tick();
      chk("sb_clear3", busy_o, 8'h00);
      chk("sb_clear3_unrsv", wr_unrsv_o, 1'b0);

      // Unreserved write to r6 still happens and pulses wr_unrsv_o once
      drive(3'b100, {3'd6, 3'd0, 3'd0}, {34'h66, 68'h0}, 1'b0, 3'd0); tick();
      chk("u6_wa", rf_wa_o, 3'd6);
      chk("u6_wd", rf_wd_o, 34'h66);
      drive(3'b000, '0, '0, 1'b0, 3'd0); tick();
      chk("u6_pulse", wr_unrsv_o, 1'b1);
      tick();
      chk("u6_pulse_end", wr_unrsv_o, 1'b0);

      // Reset while a write is staged: everything clears without a clock edge
      drive(3'b001, {3'd0, 3'd0, 3'd4}, {68'h0, 34'h3_1234_5678}, 1'b1, 3'd5); tick();
      chk("pre_rst_wen", rf_wen_o, 1'b1);
      chk("pre_rst_busy", busy_o, 8'h20);
      drive(3'b000, '0, '0, 1'b0, 3'd0);
      rst_n_i = 1'b0;
      #1;
      chk("async_wen", rf_wen_o, 1'b0);
      chk("async_wa", rf_wa_o, 3'd0);
      chk("async_wd", rf_wd_o, 34'd0);
      chk("async_busy", busy_o, 8'd0);
      chk("async_ready", req_ready_o, 3'b000);

      // Randomized run against the reference model
      do_reset();
      m_ptr = 0; m_busy = '0; m_wen = 0; m_unrsv = 0; m_wa = '0; m_wd = '0;
      pv = '0;
      for (int k = 0; k < 3; k++) begin pa[k] = '0; pd[k] = '0; end
      for (int c = 0; c < 500; c++) begin
         logic [2:0]  exp_rdy;
         logic [7:0]  nb;
         logic        rv;
         logic [2:0]  ra;
         int          w;
         for (int k = 0; k < 3; k++)
            if (!pv[k] && ($urandom_range(1, 0) == 1)) begin
               pv[k] = 1'b1;
               pa[k] = 3'($urandom_range(7, 0));
               pd[k] = {2'($urandom_range(3, 0)), 32'($urandom)};
            end
         rv = ($urandom_range(2, 0) == 0);
         ra = 3'($urandom_range(7, 0));
         drive(pv, {pa[2], pa[1], pa[0]}, {pd[2], pd[1], pd[0]}, rv, ra);
`ifdef RF_WR_BYPASS_EN
         byp_ra_i = 9'($urandom);
`endif
         #1;
         w = mdl_win(pv, m_ptr);
         exp_rdy = (w < 0) ? 3'b000 : 3'(1 << w);
         chk("rnd_ready", req_ready_o, exp_rdy);
`ifdef RF_WR_BYPASS_EN
         for (int j = 0; j < 3; j++)
            chk("rnd_byp_hit", byp_hit_o[j], m_wen && (m_wa == byp_ra_i[j*3 +: 3]));
         chk("rnd_byp_data", byp_data_o, m_wd);
`endif
         // Model edge: clear committing register first, then a reservation overrides
         nb = m_busy;
         if (m_wen) nb[m_wa] = 1'b0;
         if (rv) nb[ra] = 1'b1;
         m_unrsv = m_wen && !m_busy[m_wa];
         m_busy = nb;
         m_wen = (w >= 0);
         if (w >= 0) begin
            m_wa = pa[w];
            m_wd = pd[w];
            m_ptr = (w + 1) % 3;
            pv[w] = 1'b0;
         end
         tick();
         chk("rnd_wen", rf_wen_o, m_wen);
         chk("rnd_wa", rf_wa_o, m_wa);
         chk("rnd_wd", rf_wd_o, m_wd);
         chk("rnd_busy", busy_o, m_busy);
         chk("rnd_unrsv", wr_unrsv_o, m_unrsv);
      end

`ifdef RF_WR_BYPASS_EN
      // Directed bypass: staged write to r4, readers ask for {4,2,4}
      do_reset();
      drive(3'b001, {3'd0, 3'd0, 3'd4}, {68'h0, 34'h2_0000_0044}, 1'b0, 3'd0); tick();
      drive(3'b000, '0, '0, 1'b0, 3'd0);
      byp_ra_i = {3'd4, 3'd2, 3'd4};
      #1;
      chk("byp_hit", byp_hit_o, 3'b101);
      chk("byp_data", byp_data_o, 34'h2_0000_0044);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
